rr_arbiter8: RTL

Eight-requester round-robin arbiter that shares the single `decoder3to8` select path among up to eight masters. It registers a 3-bit winner index, drives it through an internal `decoder3to8` instance to produce a one-hot grant vector, and holds the grant until the owner releases it or a hold timeout expires. It sits between bus masters and a shared resource whose select lines are one-hot.

---
 rtl/rr_arbiter8.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with an optional hold timeout.
// The registered winner index drives a 3-to-8 decoder, so the grant
// vector depends only on registered state.

module decoder3to8 (
   input  logic [2:0] sel,
   output logic [7:0] onehot
);

   // Plain binary to one-hot decode
   always_comb begin
      onehot = 8'h00;
      onehot[sel] = 1'b1;
   end

endmodule

module rr_arbiter8 #(
   parameter int unsigned HOLD_MAX = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX);

   state_t     state, state_next;
   logic [2:0] ptr, ptr_next;
   logic [2:0] idx_next;
   logic [7:0] hold_cnt, hold_cnt_next;
   logic       valid_next;
   logic       timeout_next;
   logic [2:0] winner;
   logic [7:0] decoded;

   // Round-robin search: first requester at or after ptr, wrapping 7 -> 0
   always_comb begin
      logic       found;
      logic [2:0] cand;
      winner = ptr;
      found  = 1'b0;
      cand   = ptr;
      for (int k = 0; k < 8; k++) begin
         cand = ptr + 3'(k);
         if (!found && req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   // Next-state logic for the IDLE/GRANT controller and its registers
   always_comb begin
      logic rel_done, rel_drop, rel_expire;
      state_next    = state;
      ptr_next      = ptr;
      idx_next      = gnt_idx;
      hold_cnt_next = hold_cnt;
      valid_next    = gnt_valid;
      timeout_next  = 1'b0;
      rel_done      = done;
      rel_drop      = !req[gnt_idx];
      rel_expire    = (HOLD_MAX != 0) && (hold_cnt == HOLD_LIMIT);
      case (state)
         IDLE: begin
            valid_next = 1'b0;
            if (|req) begin
               state_next    = GRANT;
               idx_next      = winner;
               valid_next    = 1'b1;
               hold_cnt_next = 8'd1;
            end
         end
         GRANT: begin
            if (rel_done || rel_drop || rel_expire) begin
               state_next   = IDLE;
               valid_next   = 1'b0;
               ptr_next     = gnt_idx + 3'd1;
               timeout_next = rel_expire && !rel_done && !rel_drop;
            end else if (hold_cnt != 8'hFF) begin
               hold_cnt_next = hold_cnt + 8'd1;
            end
         end
         default: begin
            state_next = IDLE;
            valid_next = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= 3'd0;
         gnt_idx   <= 3'd0;
         hold_cnt  <= 8'd0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_next;
         ptr       <= ptr_next;
         gnt_idx   <= idx_next;
         hold_cnt  <= hold_cnt_next;
         gnt_valid <= valid_next;
         timeout   <= timeout_next;
      end
   end

   decoder3to8 u_dec (
      .sel    (gnt_idx),
      .onehot (decoded)
   );

   assign gnt = decoded & {8{gnt_valid}};

endmodule
